// File: rtl/divider_pkg.sv
// Shared constants, FSM state type and two's-complement helpers for the
// iterative restoring divider.
package divider_pkg;

  localparam int XLEN   = 64;
  localparam int ITER_D = 64;
  localparam int ITER_W = 32;
  localparam int CNT_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

  // Magnitude of v; the most-negative value maps to 2^(XLEN-1) as unsigned.
  function automatic logic [XLEN-1:0] abs_x(input logic [XLEN-1:0] v,
                                           input logic              is_signed);
    return (is_signed && v[XLEN-1]) ? neg_x(v) : v;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

endpackage

// File: rtl/divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, signs and RISC-V special cases applied on the final iteration.
module divider
  import divider_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] io_i_dividend,
  input  logic [XLEN-1:0] io_i_divisor,
  input  logic            io_i_div_valid,
  input  logic            io_i_divw,
  input  logic            io_i_div_signed,
  input  logic            io_i_flush,
  output logic            io_o_out_ready,
  output logic            io_o_out_valid,
  output logic [XLEN-1:0] io_o_quotient,
  output logic [XLEN-1:0] io_o_remainder
);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_w;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic [XLEN-1:0]   dvs;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   x_lat;
  logic              out_valid;
  logic [XLEN-1:0]   q_out;
  logic [XLEN-1:0]   r_out;

  logic [XLEN-1:0]   x_ext;
  logic [XLEN-1:0]   y_ext;
  logic [XLEN-1:0]   x_mag;
  logic [XLEN-1:0]   y_mag;

  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic              take;
  logic [XLEN-1:0]   rem_nx;
  logic [XLEN-1:0]   quo_nx;
  logic [XLEN-1:0]   q_sgn;
  logic [XLEN-1:0]   r_sgn;
  logic [XLEN-1:0]   q_fin;
  logic [XLEN-1:0]   r_fin;

  assign io_o_out_ready = (state == IDLE);
  assign io_o_out_valid = out_valid;
  assign io_o_quotient  = q_out;
  assign io_o_remainder = r_out;

  // Operand conditioning at accept: word ops are narrowed to 32 bits and
  // re-extended so the sign and zero tests see the effective operand.
  always_comb begin
    if (io_i_divw) begin
      x_ext = io_i_div_signed ? sext32(io_i_dividend[31:0]) : zext32(io_i_dividend[31:0]);
      y_ext = io_i_div_signed ? sext32(io_i_divisor[31:0])  : zext32(io_i_divisor[31:0]);
    end else begin
      x_ext = io_i_dividend;
      y_ext = io_i_divisor;
    end
    x_mag = abs_x(x_ext, io_i_div_signed);
    y_mag = abs_x(y_ext, io_i_div_signed);
  end

  // One restoring step; rem_sh needs XLEN+1 bits because an unsigned divisor
  // can use the full XLEN range.
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs};
    take   = ~diff[XLEN];
    rem_nx = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx = {quo[XLEN-2:0], take};
  end

  always_comb begin
    q_sgn = neg_q ? neg_x(quo_nx) : quo_nx;
    r_sgn = neg_r ? neg_x(rem_nx) : rem_nx;
    if (div_zero) begin
      q_fin = '1;
      r_fin = op_w ? sext32(x_lat[31:0]) : x_lat;
    end else if (op_w) begin
      q_fin = sext32(q_sgn[31:0]);
      r_fin = sext32(r_sgn[31:0]);
    end else begin
      q_fin = q_sgn;
      r_fin = r_sgn;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_w      <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      dvs       <= '0;
      quo       <= '0;
      rem       <= '0;
      x_lat     <= '0;
      out_valid <= 1'b0;
      q_out     <= '0;
      r_out     <= '0;
    end else if (io_i_flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (io_i_div_valid) begin
            op_w     <= io_i_divw;
            neg_q    <= io_i_div_signed & (x_ext[XLEN-1] ^ y_ext[XLEN-1]);
            neg_r    <= io_i_div_signed & x_ext[XLEN-1];
            div_zero <= (y_ext == '0);
            x_lat    <= x_ext;
            dvs      <= y_mag;
            rem      <= '0;
            // Word ops start with the dividend in the upper half so that
            // 32 shifts leave the quotient in the low half.
            quo      <= io_i_divw ? {x_mag[31:0], 32'h0} : x_mag;
            cnt      <= io_i_divw ? CNT_W'(ITER_W) : CNT_W'(ITER_D);
            state    <= BUSY;
          end
        end
        BUSY: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            q_out     <= q_fin;
            r_out     <= r_fin;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases, held-valid random
// traffic against an arithmetic reference model, flush and mid-op reset.
module tb_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] io_i_dividend;
  logic [63:0] io_i_divisor;
  logic        io_i_div_valid;
  logic        io_i_divw;
  logic        io_i_div_signed;
  logic        io_i_flush;
  logic        io_o_out_ready;
  logic        io_o_out_valid;
  logic [63:0] io_o_quotient;
  logic [63:0] io_o_remainder;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic        w;
    logic        s;
    logic [63:0] q;
    logic [63:0] r;
  } vec_t;

  vec_t tbl [12];

  always #5 clock = ~clock;

  divider #(.XLEN(64)) dut (
    .clock           (clock),
    .reset           (reset),
    .io_i_dividend   (io_i_dividend),
    .io_i_divisor    (io_i_divisor),
    .io_i_div_valid  (io_i_div_valid),
    .io_i_divw       (io_i_divw),
    .io_i_div_signed (io_i_div_signed),
    .io_i_flush      (io_i_flush),
    .io_o_out_ready  (io_o_out_ready),
    .io_o_out_valid  (io_o_out_valid),
    .io_o_quotient   (io_o_quotient),
    .io_o_remainder  (io_o_remainder)
  );

  // Reference: plain language-level division with the RISC-V special cases.
  function automatic void ref_model(input logic [63:0] x, input logic [63:0] y,
                                    input logic w, input logic s,
                                    output logic [63:0] q, output logic [63:0] r);
    int          xi, yi;
    int unsigned xu, yu;
    longint      xl, yl;
    logic [31:0] q32, r32;
    if (w) begin
      xu = x[31:0];
      yu = y[31:0];
      xi = x[31:0];
      yi = y[31:0];
      if (yu == 0) begin
        q32 = 32'hFFFF_FFFF;
        r32 = xu;
      end else if (s && xu == 32'h8000_0000 && yu == 32'hFFFF_FFFF) begin
        q32 = xu;
        r32 = 32'h0;
      end else if (s) begin
        q32 = xi / yi;
        r32 = xi % yi;
      end else begin
        q32 = xu / yu;
        r32 = xu % yu;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      xl = x;
      yl = y;
      if (y == 64'h0) begin
        q = '1;
        r = x;
      end else if (s && x == 64'h8000_0000_0000_0000 && y == '1) begin
        q = x;
        r = 64'h0;
      end else if (s) begin
        q = xl / yl;
        r = xl % yl;
      end else begin
        q = x / y;
        r = x % y;
      end
    end
  endfunction

  // Issue one request from IDLE and wait (bounded) for the result strobe.
  task automatic do_op(input logic [63:0] x, input logic [63:0] y,
                       input logic w, input logic s,
                       output logic [63:0] q, output logic [63:0] r,
                       output int lat, output logic vld_after, output logic rdy_after);
    io_i_dividend   = x;
    io_i_divisor    = y;
    io_i_divw       = w;
    io_i_div_signed = s;
    io_i_div_valid  = 1'b1;
    @(posedge clock); #1;
    io_i_div_valid = 1'b0;
    lat = 0;
    while (io_o_out_valid !== 1'b1 && lat < 80) begin
      @(posedge clock); #1;
      lat++;
    end
    q = io_o_quotient;
    r = io_o_remainder;
    @(posedge clock); #1;
    vld_after = io_o_out_valid;
    rdy_after = io_o_out_ready;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    io_i_dividend   = '0;
    io_i_divisor    = '0;
    io_i_div_valid  = 1'b0;
    io_i_divw       = 1'b0;
    io_i_div_signed = 1'b0;
    io_i_flush      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (io_o_out_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", io_o_out_ready);
    end
    vectors++;
    if (io_o_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b expected 0", io_o_out_valid);
    end
    vectors++;
    if (io_o_quotient !== 64'h0 || io_o_remainder !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_qr: got q=%h r=%h expected 0/0", io_o_quotient, io_o_remainder);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    vectors++;
    if (io_o_out_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_ready: got %b expected 1", io_o_out_ready);
    end
  endtask

  task automatic test_directed();
    logic [63:0] q, r;
    int          lat;
    logic        va, ra;
    tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[1]  = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2};
    tbl[2]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h0};
    tbl[3]  = '{64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    tbl[4]  = '{64'h0000_0001_8000_0005, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b1, 64'h0000_0000_3FFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h0};
    tbl[6]  = '{64'h0000_0001_9000_0000, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_9000_0000};
    tbl[7]  = '{64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF7};
    tbl[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 64'd1, 64'd1};
    tbl[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 64'h5555_5555_5555_5555, 64'd0};
    tbl[10] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1};
    tbl[11] = '{64'h0000_0000_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 64'h0000_0000_7FFF_FFFF, 64'd1};
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].s, q, r, lat, va, ra);
      vectors++;
      if (lat > 65) begin
        miscompares++;
        $display("FAIL dir%0d_latency: got %0d cycles expected <= 65", i, lat);
      end
      vectors++;
      if (q !== tbl[i].q) begin
        miscompares++;
        $display("FAIL dir%0d_quotient: got %h expected %h", i, q, tbl[i].q);
      end
      vectors++;
      if (r !== tbl[i].r) begin
        miscompares++;
        $display("FAIL dir%0d_remainder: got %h expected %h", i, r, tbl[i].r);
      end
      vectors++;
      if (va !== 1'b0 || ra !== 1'b1) begin
        miscompares++;
        $display("FAIL dir%0d_strobe: got valid=%b ready=%b expected valid=0 ready=1", i, va, ra);
      end
      vectors++;
      if (io_o_quotient !== tbl[i].q) begin
        miscompares++;
        $display("FAIL dir%0d_hold: got %h expected %h", i, io_o_quotient, tbl[i].q);
      end
    end
  endtask

  // Valid held high; operands change only at the result strobe.
  task automatic test_back_to_back(input int n);
    logic [63:0] x, y, eq, er;
    logic        w, s, acc, seen;
    int          lat;
    io_i_flush     = 1'b0;
    io_i_div_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: y = 64'h0;
        1: y = '1;
        2: y = 64'($urandom_range(1, 15));
        3: begin x = 64'h8000_0000_0000_0000; y = '1; end
        4: y = {32'h0, $urandom};
        5: begin x = {32'h0, $urandom}; y = 64'($urandom_range(1, 1000)); end
        6: begin x = {$urandom, 32'h8000_0000}; y = {$urandom, 32'hFFFF_FFFF}; end
        default: ;
      endcase
      w = ($urandom_range(0, 2) == 0);
      s = $urandom_range(0, 1);
      io_i_dividend   = x;
      io_i_divisor    = y;
      io_i_divw       = w;
      io_i_div_signed = s;
      ref_model(x, y, w, s, eq, er);
      lat  = 0;
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
        acc = io_o_out_ready;
        @(posedge clock); #1;
        if (acc) lat = 0;
        else     lat++;
        if (io_o_out_valid === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      vectors++;
      if (!seen || lat > 65) begin
        miscompares++;
        $display("FAIL rnd%0d_latency: got seen=%b lat=%0d expected seen=1 lat<=65", i, seen, lat);
      end
      vectors++;
      if (io_o_quotient !== eq) begin
        miscompares++;
        $display("FAIL rnd%0d_quotient: x=%h y=%h w=%b s=%b got %h expected %h", i, x, y, w, s, io_o_quotient, eq);
      end
      vectors++;
      if (io_o_remainder !== er) begin
        miscompares++;
        $display("FAIL rnd%0d_remainder: x=%h y=%h w=%b s=%b got %h expected %h", i, x, y, w, s, io_o_remainder, er);
      end
    end
    io_i_div_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_flush();
    logic [63:0] pq, pr, q, r, eq, er, x, y;
    logic        got, va, ra;
    int          lat;
    pq = io_o_quotient;
    pr = io_o_remainder;
    io_i_dividend   = 64'd1000;
    io_i_divisor    = 64'd3;
    io_i_divw       = 1'b0;
    io_i_div_signed = 1'b0;
    io_i_div_valid  = 1'b1;
    @(posedge clock); #1;
    io_i_div_valid = 1'b0;
    vectors++;
    if (io_o_out_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_busy_ready: got %b expected 0", io_o_out_ready);
    end
    repeat (9) @(posedge clock);
    #1;
    io_i_flush = 1'b1;
    @(posedge clock); #1;
    io_i_flush = 1'b0;
    vectors++;
    if (io_o_out_ready !== 1'b1 || io_o_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_abort: got ready=%b valid=%b expected ready=1 valid=0", io_o_out_ready, io_o_out_valid);
    end
    io_i_div_valid = 1'b1;
    io_i_flush     = 1'b1;
    @(posedge clock); #1;
    io_i_div_valid = 1'b0;
    io_i_flush     = 1'b0;
    vectors++;
    if (io_o_out_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_blocks_accept: got ready=%b expected 1", io_o_out_ready);
    end
    got = 1'b0;
    repeat (70) begin
      @(posedge clock); #1;
      if (io_o_out_valid === 1'b1) got = 1'b1;
    end
    vectors++;
    if (got !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_valid: got %b expected 0", got);
    end
    vectors++;
    if (io_o_quotient !== pq || io_o_remainder !== pr) begin
      miscompares++;
      $display("FAIL flush_outputs_stable: got q=%h r=%h expected q=%h r=%h", io_o_quotient, io_o_remainder, pq, pr);
    end
    x = {$urandom, $urandom};
    y = {32'h0, $urandom} | 64'h1;
    ref_model(x, y, 1'b0, 1'b1, eq, er);
    do_op(x, y, 1'b0, 1'b1, q, r, lat, va, ra);
    vectors++;
    if (lat > 65 || q !== eq || r !== er) begin
      miscompares++;
      $display("FAIL flush_next_op: got q=%h r=%h lat=%0d expected q=%h r=%h lat<=65", q, r, lat, eq, er);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] q, r, eq, er;
    logic        got, va, ra;
    int          lat;
    io_i_dividend   = 64'h1234_5678_9ABC_DEF0;
    io_i_divisor    = 64'd77;
    io_i_divw       = 1'b0;
    io_i_div_signed = 1'b1;
    io_i_div_valid  = 1'b1;
    @(posedge clock); #1;
    io_i_div_valid = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (io_o_out_valid !== 1'b0 || io_o_out_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_ctrl: got valid=%b ready=%b expected valid=0 ready=1", io_o_out_valid, io_o_out_ready);
    end
    vectors++;
    if (io_o_quotient !== 64'h0 || io_o_remainder !== 64'h0) begin
      miscompares++;
      $display("FAIL midreset_qr: got q=%h r=%h expected 0/0", io_o_quotient, io_o_remainder);
    end
    reset = 1'b0;
    got = 1'b0;
    repeat (70) begin
      @(posedge clock); #1;
      if (io_o_out_valid === 1'b1) got = 1'b1;
    end
    vectors++;
    if (got !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_valid: got %b expected 0", got);
    end
    ref_model(64'hFFFF_FFFF_FFFF_FF00, 64'd10, 1'b0, 1'b1, eq, er);
    do_op(64'hFFFF_FFFF_FFFF_FF00, 64'd10, 1'b0, 1'b1, q, r, lat, va, ra);
    vectors++;
    if (lat > 65 || q !== eq || r !== er) begin
      miscompares++;
      $display("FAIL midreset_next_op: got q=%h r=%h lat=%0d expected q=%h r=%h", q, r, lat, eq, er);
    end
  endtask

  // Inputs scrambled while BUSY must not disturb the latched operation.
  task automatic test_ignore_inputs();
    logic [63:0] x, y, eq, er;
    logic        seen;
    x = {$urandom, $urandom};
    y = {16'h0, $urandom, 16'h0} | 64'h5;
    ref_model(x, y, 1'b0, 1'b1, eq, er);
    io_i_dividend   = x;
    io_i_divisor    = y;
    io_i_divw       = 1'b0;
    io_i_div_signed = 1'b1;
    io_i_div_valid  = 1'b1;
    @(posedge clock); #1;
    repeat (5) @(posedge clock);
    #1;
    io_i_dividend   = {$urandom, $urandom};
    io_i_divisor    = 64'h0;
    io_i_divw       = 1'b1;
    io_i_div_signed = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clock); #1;
      if (io_o_out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    io_i_div_valid = 1'b0;
    vectors++;
    if (!seen || io_o_quotient !== eq || io_o_remainder !== er) begin
      miscompares++;
      $display("FAIL ignore_inputs: got seen=%b q=%h r=%h expected q=%h r=%h", seen, io_o_quotient, io_o_remainder, eq, er);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(400);
    test_flush();
    test_reset_mid();
    test_ignore_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
